// File: rtl/forest_vote.sv
// Tree-ensemble vote aggregator: registers per-tree votes, popcounts each class,
// picks the lowest-index maximum and keeps a saturating per-class result histogram.
module forest_vote #(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_TREES   = 8,
  localparam int SW = $clog2(NUM_TREES + 1),
  localparam int CW = $clog2(NUM_CLASSES),
  localparam int VW = NUM_CLASSES * NUM_TREES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [VW-1:0]           in_votes,
  input  logic [7:0]              in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           out_class,
  output logic [SW-1:0]           out_score,
  output logic                    out_tie,
  output logic [7:0]              out_tag,
  input  logic                    clr_stats,
  output logic [NUM_CLASSES*16-1:0] class_hist
);

  // Handshake: a sample moves in on in_valid && in_ready and a result moves out on
  // out_valid && out_ready. The whole pipeline advances as one unit whenever the
  // output slot is empty or being drained; otherwise every stage holds.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic                 v1;
  logic [VW-1:0]        votes1;
  logic [7:0]           tag1;
  logic                 v2;
  logic [SW-1:0]        cnt2 [NUM_CLASSES];
  logic [7:0]           tag2;
  logic [SW-1:0]        cnt_next [NUM_CLASSES];
  logic [CW-1:0]        best_idx;
  logic [SW-1:0]        best_score;
  logic                 best_tie;
  logic [NUM_CLASSES*16-1:0] hist_q;

  assign class_hist = hist_q;

  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      cnt_next[c] = '0;
      for (int t = 0; t < NUM_TREES; t++)
        cnt_next[c] = cnt_next[c] + SW'(votes1[c*NUM_TREES + t]);
    end
  end

  // A strictly larger score restarts the tie tracking; an equal one marks a tie
  // but keeps the earlier (lower) index as winner.
  always_comb begin
    best_idx   = '0;
    best_score = cnt2[0];
    best_tie   = 1'b0;
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (cnt2[c] > best_score) begin
        best_idx   = CW'(c);
        best_score = cnt2[c];
        best_tie   = 1'b0;
      end else if (cnt2[c] == best_score) begin
        best_tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      votes1    <= '0;
      tag1      <= '0;
      v2        <= 1'b0;
      tag2      <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) cnt2[c] <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      out_tie   <= 1'b0;
      out_tag   <= '0;
      hist_q    <= '0;
    end else begin
      if (advance) begin
        v1        <= in_valid;
        votes1    <= in_votes;
        tag1      <= in_tag;
        v2        <= v1;
        cnt2      <= cnt_next;
        tag2      <= tag1;
        out_valid <= v2;
        out_class <= best_idx;
        out_score <= best_score;
        out_tie   <= best_tie;
        out_tag   <= tag2;
      end
      // Clear has priority over a same-cycle delivery count.
      if (clr_stats) begin
        hist_q <= '0;
      end else if (out_valid && out_ready) begin
        for (int c = 0; c < NUM_CLASSES; c++)
          if (out_class == CW'(c) && hist_q[16*c +: 16] != 16'hFFFF)
            hist_q[16*c +: 16] <= hist_q[16*c +: 16] + 16'd1;
      end
    end
  end

endmodule
